// File: rtl/eth_tx_arb_pkg.sv
// Shared state type, statistics widths and round-robin helper for eth_tx_frame_arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DROP
    } arb_state_e;

    localparam int unsigned STAT_FRAMES_W = 32;
    localparam int unsigned STAT_TRUNC_W  = 16;
    localparam int unsigned RR_MAX_CH     = 16;

    // Unused request bits are zero, so a 16-way wrap behaves like a wrap modulo the channel count.
    function automatic logic [3:0] rr_next(input logic [RR_MAX_CH-1:0] req,
                                           input logic [3:0]           last);
        logic [3:0] idx;
        rr_next = last;
        for (int k = RR_MAX_CH; k >= 1; k--) begin
            idx = last + 4'(k);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/eth_tx_arb_rr_select.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module eth_tx_arb_rr_select
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned GW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_i,
    output logic [GW-1:0] grant_o,
    output logic          valid_o
);

    logic [RR_MAX_CH-1:0] req_ext;
    logic [3:0]           pick;

    assign req_ext = RR_MAX_CH'(req_i);
    assign pick    = rr_next(req_ext, 4'(last_i));
    assign grant_o = GW'(pick);
    assign valid_o = |req_i;

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// N-channel frame-atomic round-robin AXI-Stream TX arbiter with max-length truncation.
// Per-channel statistics are built only when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BEATS  = 1518,
    localparam int unsigned GW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [CHANNELS-1:0]                 s_axis_tvalid,
    output logic [CHANNELS-1:0]                 s_axis_tready,
    input  logic [CHANNELS-1:0]                 s_axis_tlast,
    input  logic [CHANNELS-1:0]                 s_axis_tuser,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tuser,
    output logic [GW-1:0]                       grant_id,
    output logic                                busy,
    output logic [CHANNELS*STAT_FRAMES_W-1:0]   stat_frames,
    output logic [CHANNELS*STAT_TRUNC_W-1:0]    stat_trunc
);

    localparam int unsigned   CW       = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MaxCnt   = CW'(MAX_BEATS);
    localparam logic [GW-1:0] LastInit = GW'(CHANNELS - 1);

    arb_state_e state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d, last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d, m_last_q, m_last_d, m_user_q, m_user_d;

    logic [DATA_WIDTH-1:0] ch_data [CHANNELS];
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid, src_last, src_user;
    logic [GW-1:0]         sel_grant;
    logic                  sel_valid, out_ready, accept, hit_max, trunc;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    eth_tx_arb_rr_select #(
        .N  (CHANNELS),
        .GW (GW)
    ) u_rr_select (
        .req_i   (s_axis_tvalid),
        .last_i  (last_q),
        .grant_o (sel_grant),
        .valid_o (sel_valid)
    );

    assign src_valid = s_axis_tvalid[grant_q];
    assign src_last  = s_axis_tlast[grant_q];
    assign src_user  = s_axis_tuser[grant_q];
    assign src_data  = ch_data[grant_q];
    assign out_ready = !m_valid_q || m_axis_tready;
    assign accept    = src_valid && s_axis_tready[grant_q];
    assign cnt_inc   = cnt_q + CW'(1);
    assign hit_max   = (cnt_inc == MaxCnt);
    assign trunc     = hit_max && !src_last;

    always_comb begin
        s_axis_tready = '0;
        case (state_q)
            ARB_BUSY: s_axis_tready[grant_q] = out_ready;
            ARB_DROP: s_axis_tready[grant_q] = 1'b1;
            default:  s_axis_tready = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_axis_tready;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_grant;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (accept) begin
                    cnt_d     = cnt_inc;
                    m_data_d  = src_data;
                    m_valid_d = 1'b1;
                    m_last_d  = src_last || hit_max;
                    m_user_d  = src_user || trunc;
                    if (src_last) begin
                        state_d = ARB_IDLE;
                        last_d  = grant_q;
                    end else if (hit_max) begin
                        state_d = ARB_DROP;
                    end
                end
            end
            ARB_DROP: begin
                // Remainder of an oversize frame is swallowed here.
                if (accept && src_last) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            last_q    <= LastInit;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ARB_IDLE);

`ifdef ETH_TX_ARB_STATS_EN
    logic [STAT_FRAMES_W-1:0] frames_q [CHANNELS];
    logic [STAT_TRUNC_W-1:0]  trunc_q  [CHANNELS];
    logic [GW-1:0]            out_ch_q;
    logic                     frame_done, trunc_evt;

    // Frames are counted as their last beat leaves the output register.
    assign frame_done = m_valid_q && m_axis_tready && m_last_q;
    assign trunc_evt  = (state_q == ARB_BUSY) && accept && trunc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ch_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                frames_q[i] <= '0;
                trunc_q[i]  <= '0;
            end
        end else begin
            if ((state_q == ARB_BUSY) && accept) out_ch_q <= grant_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if (frame_done && (out_ch_q == GW'(i)) && (frames_q[i] != '1)) begin
                    frames_q[i] <= frames_q[i] + 1'b1;
                end
                if (trunc_evt && (grant_q == GW'(i)) && (trunc_q[i] != '1)) begin
                    trunc_q[i] <= trunc_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_stats
        assign stat_frames[i*STAT_FRAMES_W +: STAT_FRAMES_W] = frames_q[i];
        assign stat_trunc[i*STAT_TRUNC_W +: STAT_TRUNC_W]    = trunc_q[i];
    end
`else
    assign stat_frames = '0;
    assign stat_trunc  = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter: directed scenarios plus randomized frames
// checked against a frame-level round-robin/truncation reference model.
module tb_eth_tx_frame_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXB = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          first;
        logic          fwd;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tready, m_tlast, m_tuser;
    logic [1:0]      grant_id;
    logic            busy;
    logic [N*32-1:0] stat_frames;
    logic [N*16-1:0] stat_trunc;

    beat_t src_q [N][$];
    beat_t exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    mdl_last;
    int    mdl_frames [N];
    int    mdl_trunc  [N];
    int    rdy_mode;
    bit    gap_en;
    bit    prev_stall, prev_fwd, prev_src_last;
    logic [DW+1:0] prev_out;
    logic [DW-1:0] prev_fwd_data;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter #(
        .CHANNELS   (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .grant_id      (grant_id),
        .busy          (busy),
        .stat_frames   (stat_frames),
        .stat_trunc    (stat_trunc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // user_mode: 0 none, 1 last beat only, 2 random beats
    task automatic add_frame(input int ch, input int len, input int user_mode);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = {2'(ch), 6'($urandom_range(0, 63))};
            b.last  = (k == len - 1);
            b.first = (k == 0);
            b.fwd   = (k < MAXB);
            b.user  = (user_mode == 1) ? b.last :
                      (user_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            src_q[ch].push_back(b);
        end
    endtask

    // Reference: whole frames granted round-robin among channels holding frames,
    // each cut to MAXB beats with last/user forced on the cut beat.
    task automatic build_expected();
        beat_t mq [N][$];
        beat_t b, e;
        int    ch, n;
        bit    tr;
        for (int c = 0; c < N; c++) mq[c] = src_q[c];
        do begin
            ch = -1;
            for (int k = 1; k <= N; k++) begin
                if (ch < 0 && mq[(mdl_last + k) % N].size() > 0) ch = (mdl_last + k) % N;
            end
            if (ch >= 0) begin
                n = 0;
                do begin
                    b = mq[ch].pop_front();
                    if (n < MAXB) begin
                        tr     = (n == MAXB - 1) && !b.last;
                        e      = b;
                        e.last = b.last || tr;
                        e.user = b.user || tr;
                        exp_q.push_back(e);
                        if (tr) mdl_trunc[ch]++;
                    end
                    n++;
                end while (!b.last);
                mdl_frames[ch]++;
                mdl_last = ch;
            end
        end while (ch >= 0);
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int c = 0; c < N; c++) begin
            if (src_q[c].size() > 0) begin
                b = src_q[c][0];
                s_tvalid[c]            = b.first || !gap_en || ($urandom_range(0, 3) != 0);
                s_tdata[c*DW +: DW]    = b.data;
                s_tlast[c]             = b.last;
                s_tuser[c]             = b.user;
            end else begin
                s_tvalid[c]            = 1'b0;
                s_tdata[c*DW +: DW]    = '0;
                s_tlast[c]             = 1'b0;
                s_tuser[c]             = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic cycle();
        logic [N-1:0]  acc;
        logic [DW-1:0] fwd_data;
        bit            fwd_now, last_now;
        beat_t         b, e;
        @(negedge clk);
        acc      = s_tvalid & s_tready;
        fwd_now  = 1'b0;
        last_now = 1'b0;
        fwd_data = '0;
        if (prev_fwd) begin
            check("latency_valid", 64'(m_tvalid), 64'(1));
            check("latency_data", 64'(m_tdata), 64'(prev_fwd_data));
        end
        if (prev_stall) begin
            check("stall_valid", 64'(m_tvalid), 64'(1));
            check("stall_hold", 64'({m_tdata, m_tlast, m_tuser}), 64'(prev_out));
        end
        if (prev_src_last) check("arb_gap_ready", 64'(s_tready), 64'(0));
        if (s_tready != '0) check("ready_onehot", 64'($onehot(s_tready)), 64'(1));
        for (int c = 0; c < N; c++) begin
            if (acc[c]) begin
                b = src_q[c][0];
                check("grant_id", 64'(grant_id), 64'(c));
                if (b.fwd) begin
                    fwd_now  = 1'b1;
                    fwd_data = b.data;
                end
                if (b.last) last_now = 1'b1;
            end
        end
        if (m_tvalid && m_tready) begin
            check("out_beat_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", 64'(m_tdata), 64'(e.data));
                check("out_last", 64'(m_tlast), 64'(e.last));
                check("out_user", 64'(m_tuser), 64'(e.user));
            end
        end
        prev_stall    = m_tvalid && !m_tready;
        prev_out      = {m_tdata, m_tlast, m_tuser};
        prev_fwd      = fwd_now;
        prev_fwd_data = fwd_data;
        prev_src_last = last_now;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) if (acc[c]) b = src_q[c].pop_front();
        drive_inputs();
    endtask

    task automatic start_phase(input int mode, input bit gaps);
        rdy_mode = mode;
        gap_en   = gaps;
        build_expected();
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        bit done;
        int i;
        done = 1'b0;
        i    = 0;
        while (!done && i < budget) begin
            cycle();
            i++;
            done = (exp_q.size() == 0) && !m_tvalid;
            for (int c = 0; c < N; c++) if (src_q[c].size() > 0) done = 1'b0;
        end
        check("drain_in_budget", 64'(done), 64'(1));
    endtask

    task automatic check_reset_values();
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_m_tlast", 64'(m_tlast), 64'(0));
        check("rst_m_tuser", 64'(m_tuser), 64'(0));
        check("rst_m_tdata", 64'(m_tdata), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stat_frames", 64'(stat_frames == '0), 64'(1));
        check("rst_stat_trunc", 64'(stat_trunc == '0), 64'(1));
    endtask

    task automatic check_stats();
`ifdef ETH_TX_ARB_STATS_EN
        for (int c = 0; c < N; c++) begin
            check("stat_frames", 64'(stat_frames[c*32 +: 32]), 64'(mdl_frames[c]));
            check("stat_trunc", 64'(stat_trunc[c*16 +: 16]), 64'(mdl_trunc[c]));
        end
`else
        check("stat_frames_off", 64'(stat_frames == '0), 64'(1));
        check("stat_trunc_off", 64'(stat_trunc == '0), 64'(1));
`endif
    endtask

    task automatic clear_model();
        for (int c = 0; c < N; c++) begin
            src_q[c].delete();
            mdl_frames[c] = 0;
            mdl_trunc[c]  = 0;
        end
        exp_q.delete();
        mdl_last      = N - 1;
        prev_stall    = 1'b0;
        prev_fwd      = 1'b0;
        prev_src_last = 1'b0;
    endtask

    initial begin
        int i;
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        m_tready = 1'b0;
        rdy_mode = 0;
        gap_en   = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // All channels request 3-beat frames: grant order 0,1,2,3,0
        for (int c = 0; c < N; c++) add_frame(c, 3, 0);
        add_frame(0, 3, 0);
        start_phase(0, 1'b0);
        drain(300);

        // Exactly MAX_BEATS beats ending in tlast: not truncated
        add_frame(1, MAXB, 0);
        start_phase(0, 1'b0);
        drain(300);

        // Oversize frame: cut at MAX_BEATS, remainder absorbed
        add_frame(2, MAXB + 4, 0);
        start_phase(0, 1'b0);
        drain(300);

        // MAC ready toggling every cycle
        add_frame(0, 12, 0);
        start_phase(1, 1'b0);
        drain(300);

        // Source tuser on the last beat only
        add_frame(3, 10, 1);
        start_phase(0, 1'b0);
        drain(300);
        check_stats();

        // Randomized traffic, backpressure and source gaps
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N; c++) begin
                int nf;
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) add_frame(c, $urandom_range(1, MAXB + 6), 2);
            end
            start_phase(2, 1'b1);
            drain(4000);
        end
        check_stats();

        // Reset during beat 5 of a 10-beat frame
        add_frame(2, 10, 0);
        start_phase(0, 1'b0);
        i = 0;
        while (src_q[2].size() > 6 && i < 100) begin
            cycle();
            i++;
        end
        check("reset_at_beat5", 64'(src_q[2].size()), 64'(6));
        rst = 1'b1;
        #1;
        check_reset_values();
        clear_model();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        add_frame(3, 4, 0);
        add_frame(0, 4, 0);
        start_phase(0, 1'b0);
        drain(300);
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Parametrised N-channel AXI-Stream transmit arbiter placed ahead of the 1G RGMII MAC transmit port in the Ethernet core. It merges frames from several producers onto the single MAC TX stream with round-robin, frame-atomic arbitration. It enforces a maximum frame length by truncating oversize frames and discarding the remainder. It also provides optional per-channel frame statistics.

## Interface
Parameters:
- `CHANNELS`, 4: number of input streams, 1–16.
- `DATA_WIDTH`, 8: tdata width in bits; a multiple of 8.
- `MAX_BEATS`, 1518: maximum beats per frame; the beat that reaches this count is forced last.

Ports (`N`=`CHANNELS`, `DW`=`DATA_WIDTH`):
- `clk`  in  1  single clock (gtx/logic domain, 125 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata`  in  N*DW  channel i occupies bits [i*DW +: DW].
- `s_axis_tvalid`  in  N  per-channel valid.
- `s_axis_tready`  out  N  per-channel ready.
- `s_axis_tlast`  in  N  per-channel end of frame.
- `s_axis_tuser`  in  N  per-channel bad-frame flag.
- `m_axis_tdata`  out  DW  to MAC tx_axis_tdata.
- `m_axis_tvalid`  out  1  to MAC.
- `m_axis_tready`  in  1  from MAC.
- `m_axis_tlast`  out  1  to MAC.
- `m_axis_tuser`  out  1  to MAC; set on truncated frames or when the source tuser is set.
- `grant_id`  out  $clog2(N) (min 1)  channel currently owning the output.
- `busy`  out  1  a frame is in progress (BUSY or DROP state).
- `stat_frames`  out  N*32  per-channel count of completed frames.
- `stat_trunc`  out  N*16  per-channel count of truncated frames.

## Operation
- FSM has three states:
  - IDLE: if any tvalid, grant the first requesting channel searching from (last_grant+1) mod N, wrapping. Register the grant, go to BUSY. No data moves in IDLE.
  - BUSY: only the granted channel sees `s_axis_tready` = `!m_axis_tvalid || m_axis_tready`; all other tready are 0. An accepted beat loads the output register.
    - Accepted beat with tlast: go to IDLE, last_grant ← grant.
    - Accepted beat without tlast that makes beat_cnt == MAX_BEATS: forward it with tlast=1, tuser=1, go to DROP.
  - DROP: the granted channel's tready=1 unconditionally and its beats are discarded. On an accepted tlast, go to IDLE and set last_grant ← grant.
- beat_cnt is $clog2(MAX_BEATS+1) bits wide, cleared on entry to BUSY, and incremented on each accepted beat. A frame of exactly MAX_BEATS beats ending in tlast is not truncated.
- Output tuser = source tuser OR truncation.
- Channel inputs are never reordered or interleaved within a frame.

## Timing
- Output is a single register stage. An accepted input beat appears on m_axis the next cycle.
- Arbitration costs one IDLE cycle between frames: a 1-cycle gap minimum on s_axis tready. The output stays back-to-back if the MAC stalls.
- `m_axis_tvalid` is held stable with its data until `m_axis_tready`. tvalid never drops without a handshake.
- Reset values: state IDLE; last_grant = N-1 (first grant favours channel 0); `m_axis_tvalid`/`tlast`/`tuser` = 0; `m_axis_tdata` = 0; `s_axis_tready` = 0; `grant_id` = 0; `busy` = 0; all statistics = 0.
- Reset mid-frame aborts the frame immediately. No tlast is emitted, and the MAC FIFO discards the partial frame.
- If channel i drops tvalid mid-frame, the grant is held; no timeout applies.

## Configuration
- `ETH_TX_ARB_STATS_EN`:
  - Defined: `stat_frames[i]` increments when a frame from channel i leaves the output register with tlast. `stat_trunc[i]` increments on truncation. Both counters saturate at all-ones.
  - Undefined: the counters are not synthesised, and both ports are tied to 0.

## Structure
- Package `eth_tx_arb_pkg`:
  - state enum (`ARB_IDLE`, `ARB_BUSY`, `ARB_DROP`);
  - stat widths (32, 16);
  - function `rr_next(req, last)` returning the wrapped round-robin index.
- Sub-module `eth_tx_arb_rr_select`: combinational round-robin picker (`req[N]`, `last` → `grant`, `valid`). The FSM, counters and output register stay in the top.

## Test plan
- N=4, ch1 sends a 64-beat frame with tready=1 → 64 beats out with tlast on beat 64, tuser=0, `stat_frames[1]`=1, exactly 1 latency cycle.
- All 4 channels continuously request 3-beat frames → grant order 0,1,2,3,0, with a 1-cycle tready gap between frames and no interleaving.
- MAX_BEATS=16, ch2 sends a 20-beat frame → 16 beats out, beat 16 with tlast=1/tuser=1, beats 17–20 absorbed, `stat_trunc[2]`=1.
- m_axis_tready toggles 1/0 every cycle during a frame → no beat lost or duplicated, and tvalid/data stay stable while stalled.
- Source tuser=1 on the last beat of a 10-beat frame → output tuser=1 on beat 10 only.
- Assert rst on beat 5 of a 10-beat frame → all outputs at reset values, and the next frame starts from channel 0 priority.
